// File: rtl/act_fp_lut_sym_if.sv
// Sample stream, table write port and result/drop outputs of the symmetric activation LUT.
// The master drives samples and table writes; the slave returns results and drop status.
interface act_fp_lut_sym_if #(
   parameter int DATA_W = 14,
   parameter int CNT_W  = 8
);
   logic              i_valid_pls;
   logic [DATA_W-1:0] i_x;
   logic              cfg_mode;
   logic              cfg_wr_req;
   logic [DATA_W-2:0] cfg_addr;
   logic [DATA_W-1:0] cfg_wr_data;
   logic              o_valid_pls;
   logic [DATA_W-1:0] o_act_x;
   logic              o_drop_pls;
   logic [CNT_W-1:0]  o_drop_cnt;

   modport master (
      output i_valid_pls, i_x, cfg_mode, cfg_wr_req, cfg_addr, cfg_wr_data,
      input  o_valid_pls, o_act_x, o_drop_pls, o_drop_cnt
   );

   modport slave (
      input  i_valid_pls, i_x, cfg_mode, cfg_wr_req, cfg_addr, cfg_wr_data,
      output o_valid_pls, o_act_x, o_drop_pls, o_drop_cnt
   );
endinterface

// File: rtl/act_fp_lut_sym.sv
// Half-depth activation LUT (tanh odd / sigmoid complement symmetry); fixed 3-cycle latency, 1 sample/clk.
// No backpressure: a table write colliding with a sample's read drops that sample and counts it.
module act_fp_lut_sym #(
   parameter int DATA_W = 14,
   parameter int FRAC_W = 10,
   parameter int CNT_W  = 8
) (
   input logic              clk,
   input logic              rstn,
   act_fp_lut_sym_if.slave  bus
);
   localparam int ADDR_W = DATA_W - 1;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] ONE      = DATA_W'(1) << FRAC_W;
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [ADDR_W-1:0] MAG_MAX  = '1;

   // S0: fold the input onto the non-negative half
   logic [ADDR_W-1:0] x_neg;
   logic [ADDR_W-1:0] mag_c;

   always_comb begin
      x_neg = -bus.i_x[ADDR_W-1:0];
      mag_c = bus.i_x[ADDR_W-1:0];
      if (bus.i_x == MOST_NEG) begin
         mag_c = MAG_MAX;
      end else if (bus.i_x[DATA_W-1]) begin
         mag_c = x_neg;
      end
   end

   logic              s0_vld;
   logic              s0_sign;
   logic              s0_mode;
   logic [ADDR_W-1:0] s0_mag;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s0_vld  <= 1'b0;
         s0_sign <= 1'b0;
         s0_mode <= 1'b0;
         s0_mag  <= '0;
      end else begin
         s0_vld  <= bus.i_valid_pls;
         s0_sign <= bus.i_x[DATA_W-1];
         s0_mode <= bus.cfg_mode;
         s0_mag  <= mag_c;
      end
   end

   // S1: single-port table, write wins over the read in the same cycle
   logic [DATA_W-1:0] tbl [DEPTH];
   logic [DATA_W-1:0] rd_dat;

   always_ff @(posedge clk) begin
      if (bus.cfg_wr_req) begin
         tbl[bus.cfg_addr] <= bus.cfg_wr_data;
      end else if (s0_vld) begin
         rd_dat <= tbl[s0_mag];
      end
   end

   logic s1_vld;
   logic s1_drop;
   logic s1_sign;
   logic s1_mode;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_vld  <= 1'b0;
         s1_drop <= 1'b0;
         s1_sign <= 1'b0;
         s1_mode <= 1'b0;
      end else begin
         s1_vld  <= s0_vld;
         s1_drop <= s0_vld & bus.cfg_wr_req;
         s1_sign <= s0_sign;
         s1_mode <= s0_mode;
      end
   end

   // S2: rebuild the negative half from the stored positive value
   logic [DATA_W-1:0] act_c;

   always_comb begin
      act_c = rd_dat;
      if (s1_sign) begin
         if (s1_mode) begin
            act_c = ONE - rd_dat;
         end else begin
            act_c = -rd_dat;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.o_valid_pls <= 1'b0;
         bus.o_act_x     <= '0;
         bus.o_drop_pls  <= 1'b0;
         bus.o_drop_cnt  <= '0;
      end else begin
         bus.o_valid_pls <= s1_vld & ~s1_drop;
         bus.o_drop_pls  <= s1_vld & s1_drop;
         if (s1_vld && !s1_drop) begin
            bus.o_act_x <= act_c;
         end
         if (s1_vld && s1_drop && !(&bus.o_drop_cnt)) begin
            bus.o_drop_cnt <= bus.o_drop_cnt + CNT_W'(1);
         end
      end
   end
endmodule
